// File: rtl/run_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_mon_pkg
// Purpose  : Shared types and helpers for the RISC-V run monitor.
// Revision : 1.0 - initial release
// ============================================================================
package run_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest data word the byte-swap helper accepts; callers cast down to DATA_W.
    localparam int SWAP_MAX_W = 512;

    // Reverses the byte order of the low NBYTES bytes of word.
    function automatic logic [SWAP_MAX_W-1:0] byte_swap(
        input logic [SWAP_MAX_W-1:0] word,
        input int                    nbytes
    );
        logic [SWAP_MAX_W-1:0] res;
        res = '0;
        for (int b = 0; b < SWAP_MAX_W/8; b++) begin
            if (b < nbytes) begin
                res[b*8 +: 8] = word[(nbytes-1-b)*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_mon_window.sv
`default_nettype none
// ============================================================================
// Module   : run_mon_window
// Purpose  : DEPTH x DATA_W register file, one write port, one read port.
// Revision : 1.0 - initial release
// ============================================================================
module run_mon_window
    import run_mon_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/riscv_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : riscv_run_monitor
// Purpose  : Captures a result window from the data-memory write port, compares
//            it against preloaded expected values and reports perf counters.
//            Perf counters are built only when RUN_MON_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_run_monitor
    import run_mon_pkg::*;
#(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int ARR_BEGIN = 128,
    parameter int END_ADDR  = 255,
    parameter int CNT_W     = 16,
    parameter int ERR_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     exp_wen,
    input  logic [$clog2(DEPTH)-1:0] exp_idx,
    input  logic [DATA_W-1:0]        exp_data,
    output logic                     finish,
    output logic [ERR_W-1:0]         error_num,
    output logic [$clog2(DEPTH)-1:0] first_err_idx,
    output logic                     first_err_vld,
    output logic [CNT_W-1:0]         duration,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         flush_times,
    output logic [CNT_W-1:0]         instr_count
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t             r_state;
    logic [IDX_W-1:0]   r_cmp_idx;
    logic [IDX_W-1:0]   r_first_idx;
    logic               r_first_vld;
    logic [ERR_W-1:0]   r_error_num;
    logic               r_finish;

    logic               w_run;
    logic               w_in_win;
    logic               w_end_hit;
    logic               w_cap_we;
    logic               w_exp_we;
    logic [IDX_W-1:0]   w_widx;
    logic [DATA_W-1:0]  w_swapped;
    logic [DATA_W-1:0]  w_shadow_rd;
    logic [DATA_W-1:0]  w_exp_rd;
    logic               w_mismatch;

    assign w_run     = (r_state == ST_RUN);
    assign w_in_win  = (addr >= ADDR_W'(ARR_BEGIN)) && (addr < ADDR_W'(ARR_BEGIN + DEPTH));
    assign w_end_hit = w_run && wen && (addr == ADDR_W'(END_ADDR));
    assign w_cap_we  = w_run && wen && w_in_win;
    assign w_exp_we  = w_run && exp_wen && ({1'b0, exp_idx} < (IDX_W+1)'(DEPTH));
    assign w_widx    = IDX_W'(addr - ADDR_W'(ARR_BEGIN));
    // The core stores little-endian; the shadow holds words in readable order.
    assign w_swapped = DATA_W'(byte_swap(SWAP_MAX_W'(data), DATA_W/8));

    run_mon_window #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .we    (w_cap_we),
        .waddr (w_widx),
        .wdata (w_swapped),
        .raddr (r_cmp_idx),
        .rdata (w_shadow_rd)
    );

    run_mon_window #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_expected (
        .clk   (clk),
        .rst   (rst),
        .we    (w_exp_we),
        .waddr (exp_idx),
        .wdata (exp_data),
        .raddr (r_cmp_idx),
        .rdata (w_exp_rd)
    );

    assign w_mismatch = (w_shadow_rd != w_exp_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cmp_idx   <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
            r_error_num <= '0;
            r_finish    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_end_hit) begin
                        r_state   <= ST_CMP;
                        r_cmp_idx <= '0;
                    end
                end
                ST_CMP: begin
                    if (w_mismatch) begin
                        if (r_error_num != '1) begin
                            r_error_num <= r_error_num + ERR_W'(1);
                        end
                        if (!r_first_vld) begin
                            r_first_vld <= 1'b1;
                            r_first_idx <= r_cmp_idx;
                        end
                    end
                    if (r_cmp_idx == IDX_W'(DEPTH - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cmp_idx <= r_cmp_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_finish <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign finish        = r_finish;
    assign error_num     = r_error_num;
    assign first_err_idx = r_first_idx;
    assign first_err_vld = r_first_vld;

`ifdef RUN_MON_PERF_EN
    logic [CNT_W-1:0]  r_duration;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_times;
    logic [CNT_W-1:0]  r_instr_count;
    logic [ADDR_W-1:0] r_prev_iaddr;

    // All counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duration     <= '0;
            r_stall_cycles <= '0;
            r_flush_times  <= '0;
            r_instr_count  <= '0;
            r_prev_iaddr   <= '0;
        end else begin
            r_prev_iaddr <= i_addr;
            if (r_state != ST_DONE && r_duration != '1) begin
                r_duration <= r_duration + CNT_W'(1);
            end
            if (w_run) begin
                if (stall && r_stall_cycles != '1) begin
                    r_stall_cycles <= r_stall_cycles + CNT_W'(1);
                end
                if (flush && r_flush_times != '1) begin
                    r_flush_times <= r_flush_times + CNT_W'(1);
                end
                if (i_addr != r_prev_iaddr && r_instr_count != '1) begin
                    r_instr_count <= r_instr_count + CNT_W'(1);
                end
            end
        end
    end

    assign duration     = r_duration;
    assign stall_cycles = r_stall_cycles;
    assign flush_times  = r_flush_times;
    assign instr_count  = r_instr_count;
`else
    logic w_unused_perf;
    assign w_unused_perf = ^{stall, flush, i_addr};

    assign duration     = '0;
    assign stall_cycles = '0;
    assign flush_times  = '0;
    assign instr_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_run_monitor
// Purpose  : Directed and randomized self-checking bench for riscv_run_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_run_monitor;

    localparam int ADDR_W    = 30;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int ARR_BEGIN = 128;
    localparam int END_ADDR  = 255;
    localparam int CNT_W     = 16;
    localparam int ERR_W     = 2;
    localparam int IDX_W     = 3;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int ERR_MAX   = (1 << ERR_W) - 1;

    logic              clk;
    logic              rst;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] i_addr;
    logic              exp_wen;
    logic [IDX_W-1:0]  exp_idx;
    logic [DATA_W-1:0] exp_data;
    logic              finish;
    logic [ERR_W-1:0]  error_num;
    logic [IDX_W-1:0]  first_err_idx;
    logic              first_err_vld;
    logic [CNT_W-1:0]  duration;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_times;
    logic [CNT_W-1:0]  instr_count;

    riscv_run_monitor #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ARR_BEGIN (ARR_BEGIN),
        .END_ADDR  (END_ADDR),
        .CNT_W     (CNT_W),
        .ERR_W     (ERR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wen           (wen),
        .addr          (addr),
        .data          (data),
        .stall         (stall),
        .flush         (flush),
        .i_addr        (i_addr),
        .exp_wen       (exp_wen),
        .exp_idx       (exp_idx),
        .exp_data      (exp_data),
        .finish        (finish),
        .error_num     (error_num),
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld),
        .duration      (duration),
        .stall_cycles  (stall_cycles),
        .flush_times   (flush_times),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the monitor should have seen so far.
    logic [31:0]       m_shadow [DEPTH];
    logic [31:0]       m_exp    [DEPTH];
    logic [31:0]       t_exp    [DEPTH];
    bit                m_running;
    int                m_cmp_left;
    int                m_dur, m_stall, m_flush, m_instr;
    logic [ADDR_W-1:0] m_prev;
    int                n_checks = 0;
    int                n_fail   = 0;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic sat_inc(inout int v);
        if (v < CNT_MAX) v++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_shadow[i] = '0;
            m_exp[i]    = '0;
        end
        m_running  = 1'b1;
        m_cmp_left = 0;
        m_dur      = 0;
        m_stall    = 0;
        m_flush    = 0;
        m_instr    = 0;
        m_prev     = '0;
    endtask

    task automatic idle_inputs();
        wen      = 1'b0;
        addr     = '0;
        data     = '0;
        exp_wen  = 1'b0;
        exp_idx  = '0;
        exp_data = '0;
    endtask

    task automatic rand_side();
        stall = 1'($urandom_range(0, 1));
        flush = 1'($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) i_addr = ADDR_W'($urandom_range(0, 1023));
    endtask

    // One clock edge; the model consumes the inputs sampled on that edge.
    task automatic tick();
        @(posedge clk);
        if (m_running) begin
            if (wen && addr >= ADDR_W'(ARR_BEGIN) && addr < ADDR_W'(ARR_BEGIN + DEPTH))
                m_shadow[int'(addr) - ARR_BEGIN] = bswap32(data);
            if (exp_wen && int'(exp_idx) < DEPTH)
                m_exp[exp_idx] = exp_data;
            sat_inc(m_dur);
            if (stall) sat_inc(m_stall);
            if (flush) sat_inc(m_flush);
            if (i_addr != m_prev) sat_inc(m_instr);
            if (wen && addr == ADDR_W'(END_ADDR)) begin
                m_running  = 1'b0;
                m_cmp_left = DEPTH;
            end
        end else if (m_cmp_left > 0) begin
            sat_inc(m_dur);
            m_cmp_left--;
        end
        m_prev = i_addr;
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_finish"}, 32'(finish), 32'd0);
        chk({tag, "_error_num"}, 32'(error_num), 32'd0);
        chk({tag, "_first_vld"}, 32'(first_err_vld), 32'd0);
        chk({tag, "_first_idx"}, 32'(first_err_idx), 32'd0);
        chk({tag, "_duration"}, 32'(duration), 32'd0);
        chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
        chk({tag, "_flush"}, 32'(flush_times), 32'd0);
        chk({tag, "_instr"}, 32'(instr_count), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst    = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        i_addr = '0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_zero(tag);
        rst = 1'b0;
    endtask

    task automatic load_expected();
        for (int i = 0; i < DEPTH; i++) begin
            exp_wen  = 1'b1;
            exp_idx  = IDX_W'(i);
            exp_data = t_exp[i];
            rand_side();
            tick();
        end
        idle_inputs();
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        wen  = 1'b1;
        addr = ADDR_W'(a);
        data = d;
        rand_side();
        tick();
        idle_inputs();
    endtask

    task automatic check_results(input string tag);
        int errs;
        int first;
        errs  = 0;
        first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_shadow[i] != m_exp[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_error_num"}, 32'(error_num), 32'((errs > ERR_MAX) ? ERR_MAX : errs));
        chk({tag, "_first_vld"}, 32'(first_err_vld), 32'(first >= 0));
        chk({tag, "_first_idx"}, 32'(first_err_idx), 32'((first >= 0) ? first : 0));
`ifdef RUN_MON_PERF_EN
        chk({tag, "_duration"}, 32'(duration), 32'(m_dur));
        chk({tag, "_stall"}, 32'(stall_cycles), 32'(m_stall));
        chk({tag, "_flush"}, 32'(flush_times), 32'(m_flush));
        chk({tag, "_instr"}, 32'(instr_count), 32'(m_instr));
`else
        chk({tag, "_duration"}, 32'(duration), 32'd0);
        chk({tag, "_instr"}, 32'(instr_count), 32'd0);
`endif
    endtask

    // End write, then walk the compare phase; garble injects ignored traffic.
    task automatic end_and_check(input string tag, input bit garble);
        write_word(END_ADDR, $urandom);
        for (int k = 1; k <= DEPTH + 1; k++) begin
            if (garble && k <= 3) begin
                exp_wen  = 1'b1;
                exp_idx  = IDX_W'(k);
                exp_data = $urandom;
                wen      = 1'b1;
                addr     = ADDR_W'(ARR_BEGIN + k);
                data     = $urandom;
            end
            rand_side();
            tick();
            idle_inputs();
            if (k == DEPTH || k == DEPTH + 1)
                chk($sformatf("%s_finish_edge%0d", tag, k), 32'(finish), 32'(k == DEPTH + 1));
        end
        check_results(tag);
        rand_side();
        tick();
        chk({tag, "_finish_hold"}, 32'(finish), 32'd1);
        check_results({tag, "_hold"});
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        i_addr = '0;
        idle_inputs();

        // Clean directed run: expected 1..8, little-endian writes of 1..8.
        do_reset("rst0");
        for (int i = 0; i < DEPTH; i++) t_exp[i] = 32'(i + 1);
        load_expected();
        for (int i = 0; i < DEPTH; i++) write_word(ARR_BEGIN + i, bswap32(32'(i + 1)));
        end_and_check("clean", 1'b0);
        chk("clean_errors_const", 32'(error_num), 32'd0);

        // One mismatch at element 3.
        do_reset("rst1");
        load_expected();
        for (int i = 0; i < DEPTH; i++)
            write_word(ARR_BEGIN + i, (i == 3) ? 32'h0000_0063 : bswap32(32'(i + 1)));
        end_and_check("one_err", 1'b0);
        chk("one_err_idx_const", 32'(first_err_idx), 32'd3);

        // All elements wrong: 2-bit error count saturates at 3.
        do_reset("rst2");
        load_expected();
        for (int i = 0; i < DEPTH; i++) write_word(ARR_BEGIN + i, bswap32(32'(i + 1)) ^ 32'h00FF_0000);
        end_and_check("all_err", 1'b0);
        chk("all_err_sat_const", 32'(error_num), 32'd3);

        // Directed perf pattern plus out-of-window writes and CMP-phase noise.
        do_reset("rst3");
        for (int i = 0; i < DEPTH; i++) begin
            exp_wen = 1'b1; exp_idx = IDX_W'(i); exp_data = t_exp[i];
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 20; k++) begin
            stall  = (k < 5);
            flush  = (k == 5 || k == 6);
            i_addr = ADDR_W'((k < 12) ? k + 1 : 12);
            if (k < DEPTH) begin
                wen = 1'b1; addr = ADDR_W'(ARR_BEGIN + k); data = bswap32(32'(k + 1));
            end else if (k < DEPTH + 3) begin
                wen = 1'b1; data = $urandom;
                addr = (k == DEPTH) ? ADDR_W'(127) : (k == DEPTH + 1) ? ADDR_W'(136) : ADDR_W'(200);
            end
            tick();
            idle_inputs();
        end
        stall = 1'b0;
        flush = 1'b0;
        wen = 1'b1; addr = ADDR_W'(END_ADDR); data = '0;
        tick();
        idle_inputs();
        for (int k = 1; k <= DEPTH + 1; k++) begin
            if (k <= 3) begin
                exp_wen = 1'b1; exp_idx = IDX_W'(k); exp_data = 32'hDEAD_0000;
                wen = 1'b1; addr = ADDR_W'(ARR_BEGIN + k); data = 32'hBAD0_0000;
            end
            tick();
            idle_inputs();
        end
        chk("perf_finish", 32'(finish), 32'd1);
        check_results("perf");
        chk("perf_errors_const", 32'(error_num), 32'd0);
`ifdef RUN_MON_PERF_EN
        chk("perf_stall_const", 32'(stall_cycles), 32'd5);
        chk("perf_flush_const", 32'(flush_times), 32'd2);
        chk("perf_instr_const", 32'(instr_count), 32'd12);
        chk("perf_duration_const", 32'(duration), 32'(DEPTH + 20 + 1 + DEPTH));
`endif

        // Reset in the middle of the compare phase, then a clean run.
        do_reset("rst4");
        load_expected();
        for (int i = 0; i < DEPTH; i++) write_word(ARR_BEGIN + i, 32'hFFFF_FFFF);
        write_word(END_ADDR, '0);
        tick();
        tick();
        do_reset("rst_mid_cmp");
        load_expected();
        for (int i = 0; i < DEPTH; i++) write_word(ARR_BEGIN + i, bswap32(t_exp[i]));
        end_and_check("after_rst", 1'b0);

        // Randomized runs with overwrites, strays and random mismatches.
        for (int r = 0; r < 6; r++) begin
            do_reset($sformatf("rst_rand%0d", r));
            for (int i = 0; i < DEPTH; i++) t_exp[i] = $urandom;
            load_expected();
            for (int w = 0; w < 16; w++) begin
                int a;
                int idx;
                a = ARR_BEGIN - 3 + int'($urandom_range(0, DEPTH + 5));
                idx = a - ARR_BEGIN;
                if (idx >= 0 && idx < DEPTH && $urandom_range(0, 3) != 0)
                    write_word(a, bswap32(t_exp[idx]));
                else
                    write_word(a, $urandom);
            end
            end_and_check($sformatf("rand%0d", r), 1'(r % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
